// File: rtl/mux_rr_sched_pkg.sv
// Shared types and helpers for the mux_rr_sched round-robin mux scheduler.
// Holds the FSM state encoding, the requester count and the round-robin
// pick function used by rr_arb4.
package mux_sched_pkg;

  localparam int NREQ = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GRANT  = 2'd2
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } pick_t;

  // First set request scanning last+1, last+2, ... modulo NREQ.
  function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [1:0] last);
    pick_t      res;
    logic [1:0] cand;
    res.valid = 1'b0;
    res.idx   = 2'd0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = last + 2'(k);
      if (!res.valid && req[cand]) begin
        res.valid = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

  // One-hot decode of a 2-bit source index.
  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux_rr_sched_rr_arb4.sv
// rr_arb4: combinational 4-way round-robin picker. The caller supplies the
// last-served index; the winner is the first requester after it.
import mux_sched_pkg::*;

module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic       valid,
  output logic [1:0] win
);

  pick_t pick_s;

  // Pick the next requester after the last-served pointer.
  always_comb begin
    pick_s = rr_pick(req, last);
    valid  = pick_s.valid;
    win    = pick_s.idx;
  end

endmodule

// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin scheduler sharing a dual 4:1 mux between four
// requesters. Drives the shared select pair and the active-low lane strobes
// with break-before-make settling and a per-grant time quantum.
// Optional feature macro: MUX_SCHED_LOCK_EN adds a 'lock' input that lets
// the current owner ignore quantum expiry.
import mux_sched_pkg::*;

module mux_rr_sched #(
  parameter int QUANTUM    = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef MUX_SCHED_LOCK_EN
  input  logic       lock,
`endif
  input  logic [3:0] req,
  input  logic [1:0] lane_en,
  output logic       sela,
  output logic       selb,
  output logic       e1,
  output logic       e2,
  output logic [3:0] gnt,
  output logic       busy
);

  localparam logic [7:0] QUANT_C     = 8'(QUANTUM);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_e     state_q, state_d;
  logic [1:0] win_q, win_d;
  logic [1:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] settle_q, settle_d;
  logic [1:0] sel_q, sel_d;
  logic       e1_q, e1_d;
  logic       e2_q, e2_d;
  logic [3:0] gnt_q, gnt_d;
  logic       busy_q, busy_d;

  logic       lock_s;
  logic       quantum_hit_s;
  logic [1:0] arb_last_s;
  logic       arb_valid_s;
  logic [1:0] arb_win_s;

`ifdef MUX_SCHED_LOCK_EN
  assign lock_s = lock;
`else
  assign lock_s = 1'b0;
`endif

  // While granting, the owner becomes the pointer so an exit arbitrates
  // from the new position in the same cycle.
  assign arb_last_s = (state_q == GRANT) ? win_q : last_q;

  rr_arb4 u_arb (
    .req   (req),
    .last  (arb_last_s),
    .valid (arb_valid_s),
    .win   (arb_win_s)
  );

  // Next-state, counters and output register inputs.
  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    settle_d      = settle_q;
    sel_d         = sel_q;
    e1_d          = e1_q;
    e2_d          = e2_q;
    gnt_d         = gnt_q;
    busy_d        = busy_q;
    quantum_hit_s = (cnt_q == QUANT_C) && !lock_s;
    case (state_q)
      IDLE: begin
        if (arb_valid_s) begin
          win_d    = arb_win_s;
          sel_d    = arb_win_s;
          settle_d = 4'd0;
          busy_d   = 1'b1;
          state_d  = SETTLE;
        end else begin
          busy_d   = 1'b0;
        end
      end
      SETTLE: begin
        if (!req[win_q]) begin
          // Requester gave up before being served: no grant, pointer kept.
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (settle_q == SETTLE_LAST) begin
          gnt_d   = onehot4(win_q);
          e1_d    = ~lane_en[0];
          e2_d    = ~lane_en[1];
          cnt_d   = 8'd1;  // counts grant cycles including the current one
          state_d = GRANT;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      GRANT: begin
        if (req[win_q] && !quantum_hit_s) begin
          // Saturate at the quantum so a released lock exits on the next edge.
          if (cnt_q != QUANT_C) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            cnt_d = cnt_q;
          end
          gnt_d = onehot4(win_q);
          e1_d  = ~lane_en[0];
          e2_d  = ~lane_en[1];
        end else if (req[win_q] && (arb_win_s == win_q)) begin
          // Quantum expired but nobody else is waiting: keep the mux.
          cnt_d = 8'd1;
          gnt_d = onehot4(win_q);
          e1_d  = ~lane_en[0];
          e2_d  = ~lane_en[1];
        end else begin
          gnt_d  = 4'd0;
          e1_d   = 1'b1;
          e2_d   = 1'b1;
          last_d = win_q;
          cnt_d  = 8'd0;
          if (arb_valid_s) begin
            // Strobes drop on this edge, so the select may move now.
            win_d    = arb_win_s;
            sel_d    = arb_win_s;
            settle_d = 4'd0;
            state_d  = SETTLE;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        gnt_d   = 4'd0;
        e1_d    = 1'b1;
        e2_d    = 1'b1;
        cnt_d   = 8'd0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset forces strobes off at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      win_q    <= 2'd0;
      last_q   <= 2'd3;
      cnt_q    <= 8'd0;
      settle_q <= 4'd0;
      sel_q    <= 2'd0;
      e1_q     <= 1'b1;
      e2_q     <= 1'b1;
      gnt_q    <= 4'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      sel_q    <= sel_d;
      e1_q     <= e1_d;
      e2_q     <= e2_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
    end
  end

  assign sela = sel_q[0];
  assign selb = sel_q[1];
  assign e1   = e1_q;
  assign e2   = e2_q;
  assign gnt  = gnt_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mux_rr_sched.sv
// Self-checking bench for mux_rr_sched: directed scenarios plus randomized
// request traffic, compared every cycle against a behavioural model.
// Build with MUX_SCHED_LOCK_EN defined to exercise the lock input.
module tb_mux_rr_sched;

  localparam int Q = 4;
  localparam int S = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lock_drv;
  logic [3:0] req;
  logic [1:0] lane_en;
  logic       sela, selb, e1, e2, busy;
  logic [3:0] gnt;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int         m_owner, m_cand, m_left, m_used, m_last;
  logic [1:0] m_sel;
  logic       m_e1, m_e2, m_busy;
  logic [3:0] m_gnt;

  mux_rr_sched #(.QUANTUM(Q), .SETTLE_CYC(S)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef MUX_SCHED_LOCK_EN
    .lock    (lock_drv),
`endif
    .req     (req),
    .lane_en (lane_en),
    .sela    (sela),
    .selb    (selb),
    .e1      (e1),
    .e2      (e2),
    .gnt     (gnt),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int scan(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++) begin
      if (r[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  function automatic int idx_of(input logic [3:0] g);
    for (int k = 0; k < 4; k++) begin
      if (g[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_cand = -1; m_left = 0; m_used = 0; m_last = 3;
    m_sel = 2'd0; m_e1 = 1'b1; m_e2 = 1'b1; m_gnt = 4'd0; m_busy = 1'b0;
  endtask

  // One clock edge of the scheduler rules, using inputs present at the edge.
  task automatic model_step();
    int nxt;
    bit qhit;
    if (m_owner >= 0) begin
      qhit = (m_used == Q) && !lock_drv;
      if (req[m_owner] && !qhit) begin
        if (m_used < Q) m_used++;
        m_e1 = ~lane_en[0]; m_e2 = ~lane_en[1];
      end else begin
        nxt = scan(req, m_owner);
        if (req[m_owner] && nxt == m_owner) begin
          m_used = 1;
          m_e1 = ~lane_en[0]; m_e2 = ~lane_en[1];
        end else begin
          m_last = m_owner; m_owner = -1; m_used = 0;
          m_gnt = 4'd0; m_e1 = 1'b1; m_e2 = 1'b1;
          if (nxt >= 0) begin
            m_cand = nxt; m_left = S; m_sel = nxt[1:0];
          end else begin
            m_busy = 1'b0;
          end
        end
      end
    end else if (m_cand >= 0) begin
      if (!req[m_cand]) begin
        m_cand = -1; m_busy = 1'b0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_owner = m_cand; m_cand = -1; m_used = 1;
          m_gnt = 4'(1 << m_owner);
          m_e1 = ~lane_en[0]; m_e2 = ~lane_en[1];
        end
      end
    end else begin
      nxt = scan(req, m_last);
      if (nxt >= 0) begin
        m_cand = nxt; m_left = S; m_sel = nxt[1:0]; m_busy = 1'b1;
      end
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk(tag, {23'd0, selb, sela, e1, e2, gnt, busy},
             {23'd0, m_sel, m_e1, m_e2, m_gnt, m_busy});
  endtask

  task automatic drain();
    int k;
    req = 4'd0; lock_drv = 1'b0; k = 0;
    while (busy !== 1'b0 && k < 20) begin
      cycle("drain");
      k++;
    end
    chk("drain_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [3:0] prev;
    int run, bad, gcnt;
    int owners[$];
    int lens[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};

    req = 4'b1111; lane_en = 2'b11; lock_drv = 1'b0; rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_vals", {23'd0, selb, sela, e1, e2, gnt, busy}, {23'd0, 9'b00_11_0000_0});
    rst_n = 1'b1;

    // Release: source 0 first, settle then grant.
    cycle("rel1");
    chk("rel1_sel", {25'd0, busy, selb, sela, gnt}, {25'd0, 7'b1_00_0000});
    cycle("rel2");
    chk("rel2_gnt", {26'd0, gnt, e1, e2}, {26'd0, 6'b0001_00});

    // Fairness with everyone requesting.
    owners.push_back(0); run = 1;
    repeat (30) begin
      prev = gnt;
      cycle("fair");
      if (gnt == prev && gnt != 4'd0) run++;
      else begin
        if (prev != 4'd0) lens.push_back(run);
        if (gnt != 4'd0) begin owners.push_back(idx_of(gnt)); run = 1; end
      end
    end
    chk("fair_count", {31'd0, owners.size() >= 5}, 32'd1);
    for (int i = 0; i < 5; i++) chk("fair_order", owners[i], exp_order[i]);
    for (int i = 0; i < 4; i++) chk("fair_len", lens[i], Q);

    // Early release of source 2, then 1001 must go to source 3.
    drain();
    req = 4'b0100;
    cycle("early"); cycle("early"); cycle("early");
    chk("early_gnt", {28'd0, gnt}, {28'd0, 4'b0100});
    req = 4'b0000;
    cycle("early_rel");
    chk("early_idle", {27'd0, gnt, busy}, 32'd0);
    req = 4'b1001;
    cycle("ptr");
    chk("ptr_sel", {30'd0, selb, sela}, 32'd3);
    cycle("ptr");

    // Sole requester keeps the mux across quantum boundaries.
    drain();
    req = 4'b0010;
    cycle("sole"); cycle("sole");
    bad = 0;
    repeat (12) begin
      cycle("sole");
      if (gnt != 4'b0010 || e1 || e2) bad++;
    end
    chk("sole_gap", bad, 0);

    // Lane mask: only lane 1 strobes.
    drain();
    lane_en = 2'b01; req = 4'b0100;
    bad = 0; gcnt = 0;
    repeat (6) begin
      cycle("lane");
      if (!e2) bad++;
      if (gnt != 4'd0 && !e1) gcnt++;
    end
    chk("lane_e2", bad, 0);
    chk("lane_e1", {31'd0, gcnt > 0}, 32'd1);
    lane_en = 2'b11;

    // Drop request during settle: no grant pulse.
    drain();
    req = 4'b0001;
    cycle("dset");
    req = 4'b0000;
    bad = 0;
    repeat (4) begin
      cycle("dset");
      if (gnt != 4'd0) bad++;
    end
    chk("dset_nognt", bad, 0);

`ifdef MUX_SCHED_LOCK_EN
    drain();
    lock_drv = 1'b1; req = 4'b0010;
    cycle("lock"); cycle("lock");
    req = 4'b1111;
    gcnt = 0;
    repeat (10) begin
      cycle("lock");
      if (gnt == 4'b0010) gcnt++;
    end
    chk("lock_hold", gcnt, 10);
    lock_drv = 1'b0;
    cycle("unlock");
    chk("unlock_exit", {28'd0, gnt}, 32'd0);
`endif

    // Randomized traffic.
    drain();
    repeat (1500) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(5) == 0) req[b] = ~req[b];
      if ($urandom_range(15) == 0) lane_en = 2'($urandom_range(3));
`ifdef MUX_SCHED_LOCK_EN
      if ($urandom_range(9) == 0) lock_drv = ~lock_drv;
`endif
      cycle("rand");
    end

    // Asynchronous reset mid-grant.
    drain();
    req = 4'b0010; gcnt = 0;
    while (gnt == 4'd0 && gcnt < 10) begin
      cycle("arst_wait");
      gcnt++;
    end
    chk("arst_granted", {28'd0, gnt}, {28'd0, 4'b0010});
    #2 rst_n = 1'b0;
    #1 chk("arst_out", {25'd0, gnt, e1, e2, busy}, {25'd0, 7'b0000_11_0});
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cycle("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
